mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address bits of the internal backing RAM (2^ADDR_WIDTH 32-bit words).
REQ-002 Parameter LATENCY, default 4, wait cycles between request acceptance and the first data beat; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mem_req  input  1  cache line request; held high by the cache until it sees mem_ack.
REQ-006 mem_we  input  1  1 = line writeback, 0 = line refill; sampled with mem_req.
REQ-007 mem_addr  input  32  byte address of the line; 16-byte lines of 4 words.
REQ-008 mem_wdata  input  32  write word; the cache drives it combinationally as line[mem_beat].
REQ-009 mem_rdata  output  32  read word for the current beat.
REQ-010 mem_rvalid  output  1  mem_rdata is valid this cycle (read beats only).
REQ-011 mem_wready  output  1  mem_wdata is written at the end of this cycle (write beats only).
REQ-012 mem_beat  output  2  word index within the line of the current beat.
REQ-013 mem_ack  output  1  one-cycle pulse when the transaction is complete.
REQ-014 mem_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, XFER and ACK.
REQ-016 IDLE with mem_req=1 SHALL latch mem_we and the line index mem_addr[ADDR_WIDTH+1:4], load the wait counter with LATENCY-1, and go to WAIT; upper address bits are ignored, so addresses wrap modulo the RAM size.
REQ-017 WAIT SHALL decrement the counter each cycle and go to XFER in the cycle after it reads 0, giving exactly LATENCY WAIT cycles.
REQ-018 XFER SHALL last exactly 4 cycles, one beat per cycle, with mem_beat taking the beat order in REQ-031/REQ-032.
REQ-019 On a read beat: mem_rvalid=1 and mem_rdata=RAM[{line,mem_beat}] in the same cycle; mem_wready=0.
REQ-020 On a write beat: mem_wready=1, RAM[{line,mem_beat}] is updated with mem_wdata at the clock edge ending the cycle; mem_rvalid=0.
REQ-021 After the 4th beat the FSM SHALL enter ACK for one cycle with mem_ack=1, then return to IDLE.
REQ-022 Timeline for a request sampled in IDLE at cycle 0: WAIT cycles 1..LATENCY, beats LATENCY+1..LATENCY+4, ack at LATENCY+5, IDLE at LATENCY+6.
REQ-023 mem_req is ignored outside IDLE; deasserting it mid-transaction does not abort the transaction.
REQ-024 A mem_req held high in the IDLE cycle after ACK SHALL start a new transaction (back-to-back transfers allowed).
REQ-025 mem_rvalid, mem_wready and mem_ack SHALL be 0 in every cycle outside their respective states; mem_rdata=0 when mem_rvalid=0.
REQ-026 mem_beat SHALL be 0 outside XFER.

Reset
REQ-027 rst=1 at a clock edge SHALL force the FSM to IDLE, counters to 0, and all outputs to 0, including mid-transaction; an in-flight transaction is dropped and no ack is issued.
REQ-028 A write beat in the same cycle as rst=1 SHALL NOT update the RAM.
REQ-029 RAM contents SHALL NOT be cleared by reset.
REQ-030 mem_req sampled high in the first cycle after rst deasserts SHALL be accepted normally.

Configuration
REQ-031 With macro MEM_CRITICAL_WORD_FIRST_EN defined, beats SHALL start at word mem_addr[3:2] (latched) and increment modulo 4 (e.g. start 2 gives 2,3,0,1) for both reads and writes.
REQ-032 Without MEM_CRITICAL_WORD_FIRST_EN, beats SHALL always run 0,1,2,3 and mem_addr[3:0] is ignored.

Verification
REQ-033 LATENCY=4, write line 0x40 with words A0..A3, then read 0x40 -> ack at cycle 9 of each transaction; read beats return A0..A3 in order.
REQ-034 Back-to-back: mem_req held high through ack -> new transaction enters WAIT the cycle after IDLE; mem_busy drops low for exactly one cycle.
REQ-035 rst asserted in beat 2 of a write -> all outputs 0 next cycle, no mem_ack, words 0..1 updated, words 2..3 unchanged on a later read.
REQ-036 ADDR_WIDTH=10, write line at 0x1000 then read 0x0000 -> same data returned (address wrap).
REQ-037 MEM_CRITICAL_WORD_FIRST_EN defined, read 0x48 -> mem_beat sequence 2,3,0,1 with matching data; undefined -> 0,1,2,3.
REQ-038 mem_req dropped during WAIT -> transaction completes with 4 beats and one ack pulse.

Source files
------------

// File: rtl/mem_responder.sv
// Cache-line memory responder: fixed-latency wait, four single-word beats, one-cycle ack.
// Optional macro MEM_CRITICAL_WORD_FIRST_EN starts the beats at the requested word.
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        mem_wready,
  output logic [1:0]  mem_beat,
  output logic        mem_ack,
  output logic        mem_busy
);

  localparam int         LINE_WIDTH = ADDR_WIDTH - 2;
  localparam logic [3:0] WAIT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, XFER, ACK} state_t;

  state_t                state, state_nxt;
  logic [3:0]            wait_cnt;
  logic [1:0]            beat_cnt;
  logic [1:0]            beat_base;
  logic [1:0]            cur_word;
  logic [LINE_WIDTH-1:0] line;
  logic                  we_q;
  logic                  accept;
  logic                  unused_addr;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram [2**ADDR_WIDTH];

  assign accept   = (state == IDLE) && mem_req;
  assign cur_word = beat_base + beat_cnt;
  assign ram_addr = {line, cur_word};

`ifdef MEM_CRITICAL_WORD_FIRST_EN
  assign unused_addr = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst)         beat_base <= '0;
    else if (accept) beat_base <= mem_addr[3:2];
  end
`else
  // Word offset inside the line is irrelevant when beats always run 0..3.
  assign unused_addr = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[3:0]};
  assign beat_base   = 2'b00;
`endif

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of process order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (mem_req)           state_nxt = WAIT;
      WAIT: if (wait_cnt == 4'd0)  state_nxt = XFER;
      XFER: if (beat_cnt == 2'd3)  state_nxt = ACK;
      ACK:                         state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Transaction context is captured once at acceptance and held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      beat_cnt <= '0;
      line     <= '0;
      we_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (mem_req) begin
          wait_cnt <= WAIT_INIT;
          beat_cnt <= '0;
          line     <= mem_addr[ADDR_WIDTH+1:4];
          we_q     <= mem_we;
        end
        WAIT: if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
        XFER: beat_cnt <= beat_cnt + 2'd1;
        default: ;
      endcase
    end
  end

  // NOTE: the backing RAM has no reset; rst only blocks a write beat landing on the reset edge.
  always_ff @(posedge clk) begin
    if (!rst && mem_wready) ram[ram_addr] <= mem_wdata;
  end

  always_comb begin
    mem_rdata  = '0;
    mem_rvalid = 1'b0;
    mem_wready = 1'b0;
    mem_beat   = '0;
    mem_ack    = 1'b0;
    mem_busy   = (state != IDLE);
    case (state)
      XFER: begin
        mem_beat   = cur_word;
        mem_rvalid = !we_q;
        mem_wready = we_q;
        if (!we_q) mem_rdata = ram[ram_addr];
      end
      ACK:     mem_ack = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: timeline model plus directed transactions.
// Honours MEM_CRITICAL_WORD_FIRST_EN for the expected beat order.
module tb_mem_responder;

  localparam int AW     = 10;
  localparam int LAT    = 4;
  localparam int NWORDS = 1 << AW;
  localparam int LINES  = NWORDS / 4;
`ifdef MEM_CRITICAL_WORD_FIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid, mem_wready, mem_ack, mem_busy;
  logic [1:0]  mem_beat;
  logic [31:0] wline [4];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // The bench acts as the cache: write data follows the beat index combinationally.
  assign mem_wdata = wline[mem_beat];

  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_wready(mem_wready), .mem_beat(mem_beat), .mem_ack(mem_ack), .mem_busy(mem_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: m_t counts cycles since acceptance (0 = idle); beats at LAT+1..LAT+4, ack at LAT+5.
  int          m_t = 0;
  bit          m_we = 1'b0;
  int          m_line = 0;
  int          m_start = 0;
  bit          model_ready = 1'b0;
  logic [31:0] ram_m [NWORDS];
  bit          known [NWORDS];

  function automatic bit in_xfer(input int t);
    return (t >= LAT + 1) && (t <= LAT + 4);
  endfunction

  function automatic int beat_of(input int t);
    return (m_start + t - LAT - 1) % 4;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0;
      model_ready = 1'b1;
    end else if (m_t == 0) begin
      if (mem_req) begin
        m_t     = 1;
        m_we    = mem_we;
        m_line  = int'((mem_addr >> 4) % LINES);
        m_start = CRIT ? int'((mem_addr >> 2) % 4) : 0;
      end
    end else begin
      if (m_we && in_xfer(m_t)) begin
        ram_m[m_line * 4 + beat_of(m_t)] = wline[beat_of(m_t)];
        known[m_line * 4 + beat_of(m_t)] = 1'b1;
      end
      m_t = (m_t == LAT + 5) ? 0 : m_t + 1;
    end
  end

  always @(negedge clk) begin : cmp
    bit          x;
    int          w;
    logic [31:0] e_rd;
    if (model_ready) begin
      x    = in_xfer(m_t);
      w    = x ? m_line * 4 + beat_of(m_t) : 0;
      e_rd = (x && !m_we) ? ram_m[w] : 32'h0;
      check("busy",   {31'h0, mem_busy},   {31'h0, m_t != 0});
      check("ack",    {31'h0, mem_ack},    {31'h0, m_t == LAT + 5});
      check("rvalid", {31'h0, mem_rvalid}, {31'h0, x && !m_we});
      check("wready", {31'h0, mem_wready}, {31'h0, x && m_we});
      check("beat",   {30'h0, mem_beat},   x ? 32'(beat_of(m_t)) : 32'h0);
      if (!(x && !m_we && !known[w])) check("rdata", mem_rdata, e_rd);
    end
  end

  task automatic set_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) wline[i] = base + 32'(i);
  endtask

  // Return to mid-cycle of an IDLE cycle so the next request's cycle 0 is the following negedge.
  task automatic gap();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input bit we, input logic [31:0] addr, input bit hold, input bit drop,
                      output int ack_lat, output int nbeats,
                      output logic [3:0][31:0] rd, output logic [3:0][1:0] bt,
                      output logic busy0, output logic busy1);
    int n;
    bit done;
    mem_req = 1'b1; mem_we = we; mem_addr = addr;
    n = 0; done = 1'b0; nbeats = 0; ack_lat = -1; rd = '0; bt = '0; busy0 = 1'b1; busy1 = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      if (n == 0) busy0 = mem_busy;
      if (n == 1) busy1 = mem_busy;
      if (mem_rvalid || mem_wready) begin
        if (nbeats < 4) begin
          rd[nbeats] = mem_rdata;
          bt[nbeats] = mem_beat;
        end
        nbeats++;
      end
      if (mem_ack) begin
        ack_lat = n;
        done = 1'b1;
        if (!hold) mem_req = 1'b0;
      end
      if (drop && n == 2) mem_req = 1'b0;
      n++;
    end
    check("ack_seen", {31'h0, done}, 32'h1);
  endtask

  task automatic check_words(input string name, input logic [3:0][31:0] rd,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
    check({name, "_w0"}, rd[0], e0);
    check({name, "_w1"}, rd[1], e1);
    check({name, "_w2"}, rd[2], e2);
    check({name, "_w3"}, rd[3], e3);
  endtask

  task automatic check_beats(input string name, input logic [3:0][1:0] bt,
                             input int b0, input int b1, input int b2, input int b3);
    check({name, "_b0"}, {30'h0, bt[0]}, 32'(b0));
    check({name, "_b1"}, {30'h0, bt[1]}, 32'(b1));
    check({name, "_b2"}, {30'h0, bt[2]}, 32'(b2));
    check({name, "_b3"}, {30'h0, bt[3]}, 32'(b3));
  endtask

  initial begin : stim
    int               lat, nb, n;
    bit               hit;
    logic [3:0][31:0] rd;
    logic [3:0][1:0]  bt;
    logic             b0, b1;
    logic [31:0]      ln [4];

    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0;
    set_line(32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   {31'h0, mem_busy},   32'h0);
    check("rst_ack",    {31'h0, mem_ack},    32'h0);
    check("rst_rvalid", {31'h0, mem_rvalid}, 32'h0);
    check("rst_wready", {31'h0, mem_wready}, 32'h0);
    check("rst_beat",   {30'h0, mem_beat},   32'h0);
    check("rst_rdata",  mem_rdata,           32'h0);
    rst = 1'b0;

    // Write line 0x40 then read it back.
    set_line(32'hA000_0000);
    xfer(1'b1, 32'h40, 1'b0, 1'b0, lat, nb, rd, bt, b0, b1);
    check("wr_ack_lat", 32'(lat), 32'd9);
    check("wr_nbeats",  32'(nb),  32'd4);
    check_beats("wr", bt, 0, 1, 2, 3);
    gap();
    xfer(1'b0, 32'h40, 1'b0, 1'b0, lat, nb, rd, bt, b0, b1);
    check("rd_ack_lat", 32'(lat), 32'd9);
    check("rd_busy0",   {31'h0, b0}, 32'h0);
    check_words("rd", rd, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003);

    // Back-to-back: write held through ack, read follows after exactly one idle cycle.
    gap();
    set_line(32'hB000_0000);
    xfer(1'b1, 32'h40, 1'b1, 1'b0, lat, nb, rd, bt, b0, b1);
    check("b2b_wr_ack_lat", 32'(lat), 32'd9);
    xfer(1'b0, 32'h40, 1'b0, 1'b0, lat, nb, rd, bt, b0, b1);
    check("b2b_idle_gap",   {31'h0, b0}, 32'h0);
    check("b2b_busy_again", {31'h0, b1}, 32'h1);
    check("b2b_rd_ack_lat", 32'(lat), 32'd9);
    check_words("b2b_rd", rd, 32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003);

    // Reset during beat 2 of a write: only words 0..1 change.
    gap();
    set_line(32'hC000_0000);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h40;
    n = 0; hit = 1'b0;
    while (!hit && n < 40) begin
      @(negedge clk);
      if (mem_wready && mem_beat == 2'd2) hit = 1'b1;
      n++;
    end
    check("rst_beat2_reached", {31'h0, hit}, 32'h1);
    rst = 1'b1; mem_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_busy",   {31'h0, mem_busy},   32'h0);
    check("mid_rst_wready", {31'h0, mem_wready}, 32'h0);
    check("mid_rst_ack",    {31'h0, mem_ack},    32'h0);
    check("mid_rst_beat",   {30'h0, mem_beat},   32'h0);
    xfer(1'b0, 32'h40, 1'b0, 1'b0, lat, nb, rd, bt, b0, b1);
    check("post_rst_ack_lat", 32'(lat), 32'd9);
    check_words("post_rst_rd", rd, 32'hC000_0000, 32'hC000_0001, 32'hB000_0002, 32'hB000_0003);

    // Address wrap: 0x1000 aliases line 0.
    gap();
    set_line(32'hD000_0000);
    xfer(1'b1, 32'h1000, 1'b0, 1'b0, lat, nb, rd, bt, b0, b1);
    gap();
    xfer(1'b0, 32'h0, 1'b0, 1'b0, lat, nb, rd, bt, b0, b1);
    check_words("wrap_rd", rd, 32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003);

    // Beat order for a request at word 2 of line 0x40.
    gap();
    xfer(1'b0, 32'h48, 1'b0, 1'b0, lat, nb, rd, bt, b0, b1);
    ln[0] = 32'hC000_0000; ln[1] = 32'hC000_0001; ln[2] = 32'hB000_0002; ln[3] = 32'hB000_0003;
    if (CRIT) begin
      check_beats("cwf", bt, 2, 3, 0, 1);
      check_words("cwf_rd", rd, ln[2], ln[3], ln[0], ln[1]);
    end else begin
      check_beats("seq", bt, 0, 1, 2, 3);
      check_words("seq_rd", rd, ln[0], ln[1], ln[2], ln[3]);
    end

    // Request dropped during WAIT still completes.
    gap();
    xfer(1'b0, 32'h1000, 1'b0, 1'b1, lat, nb, rd, bt, b0, b1);
    check("drop_ack_lat", 32'(lat), 32'd9);
    check("drop_nbeats",  32'(nb),  32'd4);
    check_words("drop_rd", rd, 32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
